// File: rtl/comm_pkg.sv
// ---------------------------------------------------------------------------
// comm_pkg
// Shared definitions for the BRAM pixel read/write blocks.
//   - state_e           : read-side burst states
//   - DEFAULT_*         : default word, pixel and address geometry, kept in one
//                         place so read_module and write_module pack lanes the
//                         same way (most-significant lane = first pixel)
// ---------------------------------------------------------------------------
package comm_pkg;

   localparam int          DEFAULT_DATA_WIDTH     = 32;
   localparam int          DEFAULT_PIXEL_SIZE     = 8;
   localparam int          DEFAULT_PIXEL_PER_WORD = 4;
   localparam logic [31:0] DEFAULT_INPUT_ADDR     = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      WAIT   = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/read_module_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// pixel_unpacker
// Holds one BRAM word and a lane index; presents the selected lane as a pixel.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : capture word_in, restart at the most-significant lane
//   advance      : step to the next lower lane (one pixel consumed)
//   word_in      : BRAM word to unpack
//   pixel        : lane currently selected by the index
//   index_zero   : the least-significant lane is selected (last pixel of word)
// ---------------------------------------------------------------------------
module pixel_unpacker
   import comm_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int PIXEL_SIZE     = DEFAULT_PIXEL_SIZE,
   parameter int PIXEL_PER_WORD = DEFAULT_PIXEL_PER_WORD
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  advance,
   input  logic [DATA_WIDTH-1:0] word_in,
   output logic [PIXEL_SIZE-1:0] pixel,
   output logic                  index_zero
);

   localparam int IDX_W = (PIXEL_PER_WORD > 1) ? $clog2(PIXEL_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PIXEL_PER_WORD - 1);

   logic [DATA_WIDTH-1:0] word_reg_d, word_reg_q;
   logic [IDX_W-1:0]      index_d,    index_q;

   // Next word/index: load restarts at the top lane, advance walks downwards.
   always_comb begin
      word_reg_d = word_reg_q;
      index_d    = index_q;
      if (load) begin
         word_reg_d = word_in;
         index_d    = IDX_TOP;
      end else if (advance) begin
         if (index_q == IDX_W'(0)) begin
            index_d = IDX_TOP;
         end else begin
            index_d = index_q - IDX_W'(1);
         end
      end else begin
         index_d = index_q;
      end
   end

   // Word and index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_reg_q <= {DATA_WIDTH{1'b0}};
         index_q    <= IDX_TOP;
      end else begin
         word_reg_q <= word_reg_d;
         index_q    <= index_d;
      end
   end

   // Shift the selected lane down to bit 0; the cast drops the upper lanes.
   assign pixel      = PIXEL_SIZE'(word_reg_q >> (32'(index_q) * 32'(PIXEL_SIZE)));
   assign index_zero = (index_q == IDX_W'(0));

endmodule

// File: rtl/read_module.sv
// ---------------------------------------------------------------------------
// read_module
// Reads a burst of num_words BRAM words starting at INPUT_ADDR and streams
// them out as pixels, most-significant lane first, with valid/ready handshake.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   start, num_words       : burst request (accepted only in IDLE) and length
//   bram_addr, bram_en     : BRAM byte address and read enable
//   write_enable           : BRAM byte write enables, tied off (read only)
//   bram_rdata             : BRAM read data, valid BRAM_LATENCY cycles after en
//   pixel, pixel_valid     : output pixel stream
//   pixel_ready            : consumer acceptance
//   busy, done             : not-idle flag, one-cycle end-of-burst pulse
// ---------------------------------------------------------------------------
module read_module
   import comm_pkg::*;
#(
   parameter int          DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int          ADDR_WIDTH     = 32,
   parameter logic [31:0] INPUT_ADDR     = DEFAULT_INPUT_ADDR,
   parameter int          PIXEL_SIZE     = DEFAULT_PIXEL_SIZE,
   parameter int          PIXEL_PER_WORD = DEFAULT_PIXEL_PER_WORD,
   parameter int          BRAM_LATENCY   = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] num_words,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_en,
   output logic [3:0]            write_enable,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic [PIXEL_SIZE-1:0] pixel,
   output logic                  pixel_valid,
   input  logic                  pixel_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(INPUT_ADDR);
   localparam logic [1:0]            LAT_LOAD  = 2'(BRAM_LATENCY);

   state_e                state_d, state_q;
   logic [ADDR_WIDTH-1:0] words_left_d, words_left_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [1:0]            lat_cnt_d, lat_cnt_q;
   logic                  bram_en_d, bram_en_q;
   logic                  pixel_valid_d, pixel_valid_q;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  load_s, advance_s, index_zero_s;

   pixel_unpacker #(
      .DATA_WIDTH     (DATA_WIDTH),
      .PIXEL_SIZE     (PIXEL_SIZE),
      .PIXEL_PER_WORD (PIXEL_PER_WORD)
   ) u_unpacker (
      .clk        (clk),
      .reset      (reset),
      .load       (load_s),
      .advance    (advance_s),
      .word_in    (bram_rdata),
      .pixel      (pixel),
      .index_zero (index_zero_s)
   );

   // Next-state, counters and the next value of every registered output.
   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      addr_d       = addr_q;
      lat_cnt_d    = lat_cnt_q;
      load_s       = 1'b0;
      advance_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               words_left_d = num_words;
               addr_d       = BASE_ADDR;
               state_d      = (num_words == {ADDR_WIDTH{1'b0}}) ? DONE : FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            lat_cnt_d = LAT_LOAD;
            state_d   = WAIT;
         end
         WAIT: begin
            lat_cnt_d = lat_cnt_q - 2'd1;
            // Count of one marks the cycle the BRAM word is on bram_rdata.
            if (lat_cnt_q == 2'd1) begin
               load_s  = 1'b1;
               state_d = STREAM;
            end else begin
               state_d = WAIT;
            end
         end
         STREAM: begin
            if (pixel_ready) begin
               advance_s = 1'b1;
               if (index_zero_s) begin
                  words_left_d = words_left_q - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  addr_d       = addr_q + ADDR_WIDTH'(4);
                  state_d      = (words_left_q == ADDR_WIDTH'(1)) ? DONE : FETCH;
               end else begin
                  state_d = STREAM;
               end
            end else begin
               state_d = STREAM;
            end
         end
         DONE: begin
            addr_d  = BASE_ADDR;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Outputs are decoded from the next state so they leave a flop aligned
      // with the state they belong to.
      bram_en_d     = (state_d == FETCH);
      pixel_valid_d = (state_d == STREAM);
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         words_left_q  <= {ADDR_WIDTH{1'b0}};
         addr_q        <= BASE_ADDR;
         lat_cnt_q     <= 2'd0;
         bram_en_q     <= 1'b0;
         pixel_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         words_left_q  <= words_left_d;
         addr_q        <= addr_d;
         lat_cnt_q     <= lat_cnt_d;
         bram_en_q     <= bram_en_d;
         pixel_valid_q <= pixel_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bram_addr    = addr_q;
   assign bram_en      = bram_en_q;
   assign pixel_valid  = pixel_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign write_enable = 4'b0000;

endmodule

// File: tb/tb_read_module.sv
// ---------------------------------------------------------------------------
// tb_read_module
// Drives read_module against a BRAM model with BRAM_LATENCY=2 and compares the
// pixel stream, BRAM accesses and handshake timing with a word-list model.
// ---------------------------------------------------------------------------
module tb_read_module;

   localparam int          DW   = 32;
   localparam int          AW   = 32;
   localparam int          PS   = 8;
   localparam int          PPW  = 4;
   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] num_words;
   logic [AW-1:0] bram_addr;
   logic          bram_en;
   logic [3:0]    write_enable;
   logic [DW-1:0] bram_rdata;
   logic [PS-1:0] pixel;
   logic          pixel_valid;
   logic          pixel_ready;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_bad = 0;

   logic [DW-1:0] mem     [0:63];
   logic [DW-1:0] rd_pipe [0:LAT-1];
   int            bp_pat  [4] = '{1, 0, 0, 1};

   read_module #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .INPUT_ADDR     (BASE),
      .PIXEL_SIZE     (PS),
      .PIXEL_PER_WORD (PPW),
      .BRAM_LATENCY   (LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_words    (num_words),
      .bram_addr    (bram_addr),
      .bram_en      (bram_en),
      .write_enable (write_enable),
      .bram_rdata   (bram_rdata),
      .pixel        (pixel),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // BRAM model: data appears LAT cycles after the enable, garbage otherwise.
   always @(posedge clk) begin
      rd_pipe[0] <= bram_en ? mem[bram_addr[7:2]] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_rdata = rd_pipe[LAT-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One burst of n words from BASE. ready_mode: 0 always ready, 1 pattern
   // 1,0,0,1, 2 random. Returns early after abort_after transfers (>0).
   task automatic run_burst(input int n, input int ready_mode, input int abort_after,
                            input bit inject_start);
      logic [PS-1:0] expq[$];
      logic [DW-1:0] wd;
      int  cyc, en_cnt, xfers, en_cyc, budget;
      bit  wait_first, finished, injected;
      logic rdy;
      for (int w = 0; w < n; w++) begin
         wd = mem[(BASE >> 2) + w];
         for (int l = PPW - 1; l >= 0; l--) expq.push_back(wd[l*PS +: PS]);
      end
      cyc = 0; en_cnt = 0; xfers = 0; en_cyc = 0;
      wait_first = 1'b0; finished = 1'b0; injected = 1'b0;
      budget = n * (PPW + LAT + 1) * 8 + 20;
      @(negedge clk);
      start = 1'b1;
      num_words = AW'(n);
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         num_words = AW'($urandom);
         if (bram_en) begin
            check("bram_addr", bram_addr, BASE + 32'(4 * en_cnt));
            en_cnt++;
            en_cyc = cyc;
            wait_first = 1'b1;
         end
         if (pixel_valid) begin
            if (wait_first) begin
               check("first_valid_latency", 64'(cyc - en_cyc), 64'(LAT + 1));
               wait_first = 1'b0;
            end
            if (expq.size() == 0) check("extra_pixel", 64'd1, 64'd0);
            else check("pixel", pixel, expq[0]);
         end
         check("busy_in_burst", busy, 1'b1);
         if (done) begin
            if (ready_mode == 0) check("burst_cycles", 64'(cyc), 64'(1 + n * (PPW + LAT + 1)));
            finished = 1'b1;
            // A start in the DONE cycle must not be taken.
            start = 1'b1;
            num_words = AW'(1);
            break;
         end
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = (bp_pat[cyc % 4] != 0);
            default: rdy = 1'($urandom);
         endcase
         pixel_ready = rdy;
         if (pixel_valid && rdy && expq.size() > 0) begin
            void'(expq.pop_front());
            xfers++;
            if (abort_after > 0 && xfers == abort_after) return;
         end
         if (inject_start && !injected && pixel_valid && xfers == 1) begin
            start = 1'b1;
            num_words = AW'(n + 5);
            injected = 1'b1;
         end
      end
      if (!finished) check("done_timeout", 64'd0, 64'd1);
      check("bram_en_count", 64'(en_cnt), 64'(n));
      check("pixel_count", 64'(xfers), 64'(n * PPW));
      check("pixels_left", 64'(expq.size()), 64'd0);
      @(negedge clk);
      start = 1'b0;
      check("done_width", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_addr", bram_addr, BASE);
      check("idle_valid", pixel_valid, 1'b0);
      @(negedge clk);
      check("start_in_done_ignored", {busy, bram_en}, 2'b00);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      num_words = '0;
      pixel_ready = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      repeat (2) @(negedge clk);
      check("rst_outputs", {bram_en, pixel_valid, busy, done, pixel}, {4'b0000, 8'h00});
      check("rst_addr", bram_addr, BASE);
      check("write_enable", write_enable, 4'b0000);
      reset = 1'b0;

      // Single word, always ready.
      mem[0] = 32'hAABB_CCDD;
      run_burst(1, 0, 0, 1'b0);
      // Backpressure 1,0,0,1.
      run_burst(2, 1, 0, 1'b0);
      // Three-word burst.
      run_burst(3, 0, 0, 1'b0);
      // Zero length.
      run_burst(0, 0, 0, 1'b0);
      // Start while streaming is ignored.
      run_burst(2, 0, 0, 1'b1);

      // Reset after two pixels of a burst.
      run_burst(2, 0, 2, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_outputs", {bram_en, pixel_valid, busy, done, pixel}, {4'b0000, 8'h00});
      check("midrst_addr", bram_addr, BASE);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("after_rst_quiet", {bram_en, pixel_valid, busy}, 3'b000);
      end
      mem[0] = 32'hAABB_CCDD;
      run_burst(1, 0, 0, 1'b0);

      // Random contents, lengths and ready.
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 8; i++) mem[i] = $urandom;
         run_burst(int'($urandom_range(1, 5)), 2, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/read_module.md
READ_MODULE -- requirements
Module: read_module

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per BRAM word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning BRAM address width.
REQ-003 SHALL have parameter INPUT_ADDR, default 32'h0000_0000, meaning BRAM byte address of the first word to read.
REQ-004 SHALL have parameter PIXEL_SIZE, default 8, meaning bits per pixel.
REQ-005 SHALL have parameter PIXEL_PER_WORD, default 4, meaning pixels per BRAM word.
REQ-006 SHALL have parameter BRAM_LATENCY, default 1, range 1..3, meaning cycles from bram_en to valid bram_rdata.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, a one-cycle request to begin a read burst.
REQ-010 SHALL have port num_words, input, ADDR_WIDTH, the number of words in the burst, sampled when start is accepted.
REQ-011 SHALL have port bram_addr, output, ADDR_WIDTH, the BRAM byte address.
REQ-012 SHALL have port bram_en, output, 1, the BRAM read enable.
REQ-013 SHALL have port write_enable, output, 4, the BRAM byte write enables, constantly 4'b0000.
REQ-014 SHALL have port bram_rdata, input, DATA_WIDTH, the BRAM read data.
REQ-015 SHALL have port pixel, output, PIXEL_SIZE, the current output pixel.
REQ-016 SHALL have port pixel_valid, output, 1, asserted while pixel holds valid data.
REQ-017 SHALL have port pixel_ready, input, 1, the consumer's acceptance signal; a transfer occurs when pixel_valid and pixel_ready are both high.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-019 SHALL have port done, output, 1, a one-cycle pulse when a burst completes.

Function
REQ-020 SHALL implement states IDLE, FETCH, WAIT, STREAM and DONE.
REQ-021 SHALL, in IDLE with start=1, latch num_words into words_left, set bram_addr=INPUT_ADDR and go to FETCH, or go to DONE if num_words=0.
REQ-022 SHALL ignore start in every state except IDLE.
REQ-023 SHALL, in FETCH, assert bram_en for exactly one cycle, load latency counter=BRAM_LATENCY and go to WAIT.
REQ-024 SHALL, in WAIT, decrement the latency counter each cycle and, on the cycle the data is valid, capture bram_rdata into word_reg, set index=PIXEL_PER_WORD-1 and go to STREAM; the first pixel_valid SHALL therefore occur BRAM_LATENCY+1 cycles after bram_en.
REQ-025 SHALL, in STREAM, drive pixel_valid=1 and pixel=word_reg[index*PIXEL_SIZE +: PIXEL_SIZE], so the most-significant lane is emitted first, matching the write_module packing order.
REQ-026 SHALL hold pixel and pixel_valid stable while pixel_ready=0.
REQ-027 SHALL decrement index on each transfer.
REQ-028 SHALL, on the transfer at index=0, decrement words_left, add 4 to bram_addr (modulo 2^ADDR_WIDTH), and go to DONE if the new words_left=0, else to FETCH.
REQ-029 SHALL, in DONE, assert done for one cycle, restore bram_addr=INPUT_ADDR and return to IDLE.
REQ-030 SHALL not accept a start presented in the DONE cycle.
REQ-031 SHALL keep bram_en=0 and pixel_valid=0 in every state other than the one specified for it.
REQ-032 SHALL achieve a steady-state throughput of PIXEL_PER_WORD pixels per PIXEL_PER_WORD+BRAM_LATENCY+1 cycles under constant pixel_ready=1.

Reset
REQ-033 SHALL, on reset, immediately set state=IDLE, bram_addr=INPUT_ADDR, bram_en=0, pixel=0, pixel_valid=0, busy=0, done=0, word_reg=0, index=PIXEL_PER_WORD-1 and words_left=0.
REQ-034 SHALL, when reset is asserted mid-burst, abandon the burst with no further BRAM access or pixel output after release until a new start.

Structure
REQ-035 SHALL define the state enum (IDLE, FETCH, WAIT, STREAM, DONE) and the shared defaults (DATA_WIDTH, PIXEL_SIZE, PIXEL_PER_WORD, INPUT_ADDR) in package comm_pkg, which write_module also imports.
REQ-036 SHALL use one sub-module, pixel_unpacker, holding word_reg and index, with load, advance and pixel outputs; the FSM, address counter and latency counter SHALL remain in read_module.

Verification
REQ-037 SHALL cover a single word: num_words=1, BRAM[0]=32'hAABBCCDD, pixel_ready=1 -> pixels AA, BB, CC, DD on consecutive cycles, bram_en once at addr 0, then done pulse.
REQ-038 SHALL cover backpressure: pixel_ready toggling 1,0,0,1 -> each pixel held stable until accepted, with no loss or duplication.
REQ-039 SHALL cover a multi-word burst: num_words=3 at 0x00, 0x04, 0x08, BRAM_LATENCY=2 -> 12 pixels in order, 3 bram_en pulses, bram_addr back to INPUT_ADDR after done.
REQ-040 SHALL cover the zero-length case: num_words=0 -> done one cycle after start, no bram_en, no pixel_valid.
REQ-041 SHALL cover reset mid-STREAM after 2 pixels: outputs take reset values immediately, nothing further is emitted, and a new start of 1 word behaves as in REQ-037.
REQ-042 SHALL cover start during busy: a start pulse in STREAM -> ignored, burst length unchanged.
